// File: rtl/bsg_clk_gen_pearl_pkg.sv
// Shared types and constants for the clock-generator pearl helper blocks.
package bsg_clk_gen_pearl_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StArm,
        StCount,
        StDone
    } bsg_clk_gen_pearl_freq_meter_state_e;

    localparam int unsigned bsg_clk_gen_pearl_freq_meter_arm_cycles_gp = 3;

    // Arm counter width; must hold arm_cycles_gp-1.
    localparam int unsigned bsg_clk_gen_pearl_freq_meter_arm_cnt_width_gp = 2;

endpackage

// File: rtl/bsg_clk_gen_pearl_edge_detect.sv
// Two-flop synchronizer plus history flop; rise_o pulses for one clk_i cycle per
// synchronized rising edge of clk_monitor_i.
module bsg_clk_gen_pearl_edge_detect (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic clk_monitor_i,
    output logic rise_o
);

    logic [1:0] sync_q;
    logic       hist_q;

    // sync_q[0] is the metastability-catching flop; only sync_q[1] is used downstream.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sync_q <= 2'b00;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], clk_monitor_i};
            hist_q <= sync_q[1];
        end
    end

    assign rise_o = sync_q[1] & ~hist_q;

endmodule

// File: rtl/bsg_clk_gen_pearl_freq_meter.sv
// Counts rising edges of the pearl monitor clock over an N-cycle reference window.
// Define BSG_CLK_GEN_PEARL_FREQ_METER_CONTINUOUS_EN to re-arm automatically on yumi_i.
module bsg_clk_gen_pearl_freq_meter
    import bsg_clk_gen_pearl_pkg::*;
#(
    parameter int unsigned window_width_p = 16,
    parameter int unsigned count_width_p  = 24
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      clk_monitor_i,
    input  logic                      start_i,
    input  logic [window_width_p-1:0] window_cycles_i,
    output logic                      busy_o,
    output logic                      v_o,
    output logic [count_width_p-1:0]  count_o,
    output logic                      overflow_o,
    input  logic                      yumi_i
);

    localparam int unsigned ArmW = bsg_clk_gen_pearl_freq_meter_arm_cnt_width_gp;
    localparam logic [ArmW-1:0] ArmLast =
        ArmW'(bsg_clk_gen_pearl_freq_meter_arm_cycles_gp - 1);
    localparam logic [window_width_p-1:0] WindowOne = window_width_p'(1);

    bsg_clk_gen_pearl_freq_meter_state_e state_q, state_d;
    logic [ArmW-1:0]           arm_cnt_q, arm_cnt_d;
    logic [window_width_p-1:0] window_q, window_d;
    logic [count_width_p-1:0]  count_q, count_d;
    logic                      overflow_q, overflow_d;
    logic                      rise;

`ifdef BSG_CLK_GEN_PEARL_FREQ_METER_CONTINUOUS_EN
    // Window length kept for automatic re-arm, since window_q is consumed by counting.
    logic [window_width_p-1:0] n_q, n_d;
`endif

    bsg_clk_gen_pearl_edge_detect u_edge_detect (
        .clk_i         (clk_i),
        .reset_n_i     (reset_n_i),
        .clk_monitor_i (clk_monitor_i),
        .rise_o        (rise)
    );

    always_comb begin
        state_d    = state_q;
        arm_cnt_d  = arm_cnt_q;
        window_d   = window_q;
        count_d    = count_q;
        overflow_d = overflow_q;
`ifdef BSG_CLK_GEN_PEARL_FREQ_METER_CONTINUOUS_EN
        n_d        = n_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    window_d   = window_cycles_i;
                    count_d    = '0;
                    overflow_d = 1'b0;
                    arm_cnt_d  = '0;
                    state_d    = StArm;
`ifdef BSG_CLK_GEN_PEARL_FREQ_METER_CONTINUOUS_EN
                    n_d        = window_cycles_i;
`endif
                end
            end

            // Synchronizer runs continuously; ARM only waits for stale levels to drain.
            StArm: begin
                if (arm_cnt_q == ArmLast) begin
                    state_d = (window_q == '0) ? StDone : StCount;
                end else begin
                    arm_cnt_d = arm_cnt_q + 1'b1;
                end
            end

            StCount: begin
                window_d = window_q - 1'b1;
                if (rise) begin
                    if (&count_q) begin
                        overflow_d = 1'b1;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
                if (window_q == WindowOne) begin
                    state_d = StDone;
                end
            end

            StDone: begin
                if (yumi_i) begin
`ifdef BSG_CLK_GEN_PEARL_FREQ_METER_CONTINUOUS_EN
                    window_d   = n_q;
                    count_d    = '0;
                    overflow_d = 1'b0;
                    arm_cnt_d  = '0;
                    state_d    = StArm;
`else
                    state_d    = StIdle;
`endif
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= StIdle;
            arm_cnt_q  <= '0;
            window_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            arm_cnt_q  <= arm_cnt_d;
            window_q   <= window_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef BSG_CLK_GEN_PEARL_FREQ_METER_CONTINUOUS_EN
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            n_q <= '0;
        end else begin
            n_q <= n_d;
        end
    end
`endif

    assign busy_o     = (state_q == StArm) || (state_q == StCount);
    assign v_o        = (state_q == StDone);
    assign count_o    = count_q;
    assign overflow_o = overflow_q;

endmodule
